// File: rtl/accel_pwr_seq.sv
// Accelerator socket power sequencer: ordered clock/iso/retain/power steps.
// Optional rail-good wait and timeout error: define ACCEL_PWR_PGOOD_EN.
module accel_pwr_seq #(
  parameter int PWR_UP_CYC    = 8,
  parameter int ISO_CYC       = 2,
  parameter int PWR_DN_CYC    = 4,
  parameter int PGOOD_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pwr_req_i,
  input  logic       retain_req_i,
`ifdef ACCEL_PWR_PGOOD_EN
  input  logic       pwr_good_i,
  output logic       pwr_err_o,
`endif
  output logic       power_en_o,
  output logic       isolate_o,
  output logic       retain_o,
  output logic       clk_en_o,
  output logic       pwr_ack_o,
  output logic       busy_o,
  output logic [2:0] state_o
);

  localparam int UP_C = (PWR_UP_CYC < 1) ? 1 : PWR_UP_CYC;
  localparam int IS_C = (ISO_CYC < 1) ? 1 : ISO_CYC;
  localparam int DN_C = (PWR_DN_CYC < 1) ? 1 : PWR_DN_CYC;
  localparam int TO_C = (PGOOD_TIMEOUT < 1) ? 1 : PGOOD_TIMEOUT;
  localparam int M1   = (UP_C > IS_C) ? UP_C : IS_C;
  localparam int M2   = (M1 > DN_C) ? M1 : DN_C;
  localparam int MAXV = (M2 > TO_C) ? M2 : TO_C;
  localparam int CW   = $clog2(MAXV) + 1;

  localparam logic [CW-1:0] UP_T = CW'(UP_C - 1);
  localparam logic [CW-1:0] IS_T = CW'(IS_C - 1);
  localparam logic [CW-1:0] DN_T = CW'(DN_C - 1);

  typedef enum logic [2:0] {
    S_OFF     = 3'd0,
    S_PU_RAMP = 3'd1,
    S_PU_REL  = 3'd2,
    S_ON      = 3'd3,
    S_PD_CLK  = 3'd4,
    S_PD_ISO  = 3'd5,
    S_PD_PWR  = 3'd6
  } st_t;

  st_t           st_q, st_d;
  logic [CW-1:0] cnt_q;
  logic          lat_q, lat_d;
  logic          pe_d, iso_d, ret_d, ce_d, ack_d, busy_d;

`ifdef ACCEL_PWR_PGOOD_EN
  localparam logic [CW-1:0] TO_T = CW'(TO_C - 1);
  logic err_q, err_d;
  logic seen_q, seen_d;
`endif

  always_comb begin
    st_d  = st_q;
    lat_d = lat_q;
`ifdef ACCEL_PWR_PGOOD_EN
    err_d  = err_q;
    seen_d = seen_q;
`endif
    case (st_q)
      S_OFF: begin
`ifdef ACCEL_PWR_PGOOD_EN
        // after a failed ramp, require one low sample before retrying
        if (err_q && !pwr_req_i)
          seen_d = 1'b1;
        if (pwr_req_i && (!err_q || seen_q)) begin
          st_d   = S_PU_RAMP;
          err_d  = 1'b0;
          seen_d = 1'b0;
        end
`else
        if (pwr_req_i)
          st_d = S_PU_RAMP;
`endif
      end
      S_PU_RAMP: begin
`ifdef ACCEL_PWR_PGOOD_EN
        if (cnt_q >= UP_T && pwr_good_i) begin
          st_d  = S_PU_REL;
          lat_d = 1'b0;
        end else if (cnt_q >= TO_T) begin
          st_d  = S_PD_PWR;
          err_d = 1'b1;
          lat_d = 1'b0;
        end
`else
        if (cnt_q == UP_T) begin
          st_d  = S_PU_REL;
          lat_d = 1'b0;
        end
`endif
      end
      S_PU_REL:
        if (cnt_q == IS_T)
          st_d = S_ON;
      S_ON:
        if (!pwr_req_i) begin
          st_d  = S_PD_CLK;
          lat_d = retain_req_i;
        end
      S_PD_CLK:
        if (cnt_q == IS_T)
          st_d = S_PD_ISO;
      S_PD_ISO:
        if (cnt_q == IS_T)
          st_d = S_PD_PWR;
      S_PD_PWR:
        if (cnt_q == DN_T)
          st_d = S_OFF;
      default:
        st_d = S_OFF;
    endcase
  end

  // outputs decoded from the next state so they register with it
  always_comb begin
    pe_d   = 1'b0;
    iso_d  = 1'b1;
    ret_d  = lat_d;
    ce_d   = 1'b0;
    ack_d  = 1'b0;
    busy_d = 1'b1;
    unique case (st_d)
      S_OFF:     busy_d = 1'b0;
      S_PU_RAMP: pe_d = 1'b1;
      S_PU_REL: begin
        pe_d  = 1'b1;
        iso_d = 1'b0;
        ret_d = 1'b0;
      end
      S_ON: begin
        pe_d   = 1'b1;
        iso_d  = 1'b0;
        ret_d  = 1'b0;
        ce_d   = 1'b1;
        ack_d  = 1'b1;
        busy_d = 1'b0;
      end
      S_PD_CLK: begin
        pe_d  = 1'b1;
        iso_d = 1'b0;
        ret_d = 1'b0;
      end
      S_PD_ISO:  pe_d = 1'b1;
      S_PD_PWR:  pe_d = 1'b0;
      default:   busy_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q       <= S_OFF;
      cnt_q      <= '0;
      lat_q      <= 1'b0;
      power_en_o <= 1'b0;
      isolate_o  <= 1'b1;
      retain_o   <= 1'b0;
      clk_en_o   <= 1'b0;
      pwr_ack_o  <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      st_q       <= st_d;
      lat_q      <= lat_d;
      power_en_o <= pe_d;
      isolate_o  <= iso_d;
      retain_o   <= ret_d;
      clk_en_o   <= ce_d;
      pwr_ack_o  <= ack_d;
      busy_o     <= busy_d;
      if (st_d != st_q)
        cnt_q <= '0;
      else if (cnt_q != '1)
        cnt_q <= cnt_q + 1'b1;
    end
  end

`ifdef ACCEL_PWR_PGOOD_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q     <= 1'b0;
      seen_q    <= 1'b0;
      pwr_err_o <= 1'b0;
    end else begin
      err_q     <= err_d;
      seen_q    <= seen_d;
      pwr_err_o <= err_d;
    end
  end
`endif

  assign state_o = st_q;

endmodule

// File: doc/accel_pwr_seq.md
Name: accel_pwr_seq

Overview:
- Power-control sequencer that drives the power-management side of one accelerator socket: power_en, isolate, retain, clk_en.
- A level request from the SoC power manager is turned into a glitch-free, ordered sequence.
  - Power-down order: clock gate, then isolate, then retain, then power off.
  - Power-up order: the reverse.
- Reports stable on/off via an ack level. Sits in the always-on domain, one instance per socket.

Parameters:
- PWR_UP_CYC, 8, cycles spent in PU_RAMP after power_en rises, before release. Value 0 is treated as 1.
- ISO_CYC, 2, cycles spent in each isolation/clock step (PU_REL, PD_CLK, PD_ISO). Value 0 is treated as 1.
- PWR_DN_CYC, 4, cycles spent in PD_PWR after power_en falls, before OFF is reported. Value 0 is treated as 1.
- PGOOD_TIMEOUT, 64, maximum cycles to wait for pwr_good_i. Used only with ACCEL_PWR_PGOOD_EN.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- pwr_req_i  in  1  1 = accelerator on requested, 0 = off requested.
- retain_req_i  in  1  keep retention state across power-off. Sampled when leaving ON.
- power_en_o  out  1  socket power switch enable.
- isolate_o  out  1  output isolation clamp enable.
- retain_o  out  1  retention flop save/hold.
- clk_en_o  out  1  socket clock gate enable.
- pwr_ack_o  out  1  1 only in ON state.
- busy_o  out  1  1 in any transitional state.
- state_o  out  3  current state encoding, for debug.
- pwr_good_i  in  1  rail good. Present only with ACCEL_PWR_PGOOD_EN.
- pwr_err_o  out  1  sticky power-up failure. Present only with ACCEL_PWR_PGOOD_EN.

Behaviour:
- One clock domain. Reset is asynchronous, active-low, on rst_n.
- All outputs are registered and Moore-decoded from the state, with no combinational path from inputs.
- Reset values: state OFF, power_en_o=0, isolate_o=1, retain_o=0, clk_en_o=0, pwr_ack_o=0, busy_o=0, pwr_err_o=0, counter 0.
- Reset mid-sequence aborts immediately to the OFF values. Retention is lost.
- States and encodings (state_o):
  - OFF (0): power_en 0, isolate 1, clk_en 0, retain = latched value. If pwr_req_i=1 (and no error block), go to PU_RAMP.
  - PU_RAMP (1): power_en 1, isolate 1, clk_en 0, retain held. Stay max(PWR_UP_CYC,1) cycles, then go to PU_REL.
  - PU_REL (2): retain 0, isolate 0, clk_en 0. Stay max(ISO_CYC,1) cycles, then go to ON.
  - ON (3): clk_en 1, pwr_ack 1. If pwr_req_i=0, latch retain_req_i and go to PD_CLK.
  - PD_CLK (4): clk_en 0, isolate 0. Stay ISO_CYC cycles, then go to PD_ISO.
  - PD_ISO (5): isolate 1, retain = latched value. Stay ISO_CYC cycles, then go to PD_PWR.
  - PD_PWR (6): power_en 0. Stay max(PWR_DN_CYC,1) cycles, then go to OFF.
- Counter:
  - Width is $clog2 of the largest of the cycle parameters and PGOOD_TIMEOUT, plus 1.
  - Loaded on every state entry; state exits when the count reaches the terminal value.
- Requests are sampled only in OFF and ON.
  - pwr_req_i changes during a transitional state are ignored.
  - The level is re-evaluated on arrival at the stable state. A request that reversed mid-sequence therefore starts the opposite sequence on the next cycle.
- Invariants (assert in bench):
  - clk_en_o=1 implies isolate_o=0 and power_en_o=1.
  - power_en_o=0 implies isolate_o=1.
  - retain_o never changes in the same cycle as power_en_o.
- Latency:
  - pwr_req_i rise to pwr_ack_o=1 is 1 + PWR_UP_CYC + ISO_CYC cycles.
  - pwr_req_i fall to pwr_ack_o=0 is 1 cycle.
  - pwr_req_i fall to OFF is 1 + 2*ISO_CYC + PWR_DN_CYC cycles.

Optional Feature:
- Macro ACCEL_PWR_PGOOD_EN.
- Defined: pwr_good_i and pwr_err_o ports exist.
  - PU_RAMP lasts at least PWR_UP_CYC cycles, then additionally waits for pwr_good_i=1.
  - If pwr_good_i=1 is not seen within PGOOD_TIMEOUT cycles of PU_RAMP entry: set pwr_err_o=1, go to PD_PWR (power_en 0, isolate 1, retain 0), then OFF.
  - While pwr_err_o=1, OFF ignores pwr_req_i until pwr_req_i=0 has been seen for 1 cycle.
  - pwr_err_o clears on the next PU_RAMP entry.
  - pwr_good_i is ignored in ON.
- Undefined: ports are absent and PU_RAMP is a fixed count.

Test Plan:
- Power-up: defaults, pwr_req_i 0->1 at edge 0 -> power_en_o=1 after edge 1, isolate_o=0 after edge 9, clk_en_o=1 and pwr_ack_o=1 after edge 11, busy_o high edges 1-10.
- Power-down with retain: retain_req_i=1, pwr_req_i 1->0 at edge 0 -> clk_en_o=0 after edge 1, isolate_o=1 after edge 3, retain_o=1 from edge 3, power_en_o=0 after edge 5, state_o=0 after edge 9, retain_o stays 1. Next power-up: retain_o falls with isolate_o in PU_REL.
- Request glitch: pwr_req_i 1 for 1 cycle during OFF -> full power-up completes to ON, then the power-down sequence starts the next cycle. The invariants hold every cycle.
- Reset mid-sequence: rst_n low during PU_REL -> outputs at reset values asynchronously (power_en_o=0, isolate_o=1, clk_en_o=0) before the next clk edge.
- Zero parameters: PWR_UP_CYC=ISO_CYC=PWR_DN_CYC=0 -> each wait state lasts exactly 1 cycle, up latency 3 cycles.
- ACCEL_PWR_PGOOD_EN, pwr_good_i stuck 0, PGOOD_TIMEOUT=64 -> pwr_err_o=1 64 cycles after PU_RAMP entry, power_en_o=0, no retry until pwr_req_i=0 for 1 cycle.
